// File: rtl/beta_useq.sv
// Micro-sequencer between decoder and execute: handshaked issue, memory wait with timeout, trap and flush.
// Optional performance counters are built when BETA_USEQ_PERF_EN is defined.
module beta_useq #(
   parameter int ADDR_W      = 9,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32,
   parameter int CW_W        = 32,
   parameter int MEM_OP_BIT  = 0
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              instr_valid_i,
   output logic              instr_ready_o,
   input  logic [ADDR_W-1:0] cu_address_i,
   input  logic [CW_W-1:0]   cw_i,
   input  logic              invalid_instr_i,
   input  logic              flush_i,
   output logic [CW_W-1:0]   control_word_o,
   output logic              cw_valid_o,
   input  logic              mem_ack_i,
   output logic              trap_o,
   output logic [1:0]        trap_cause_o,
   output logic [ADDR_W-1:0] trap_addr_o,
   input  logic              trap_ack_i,
   output logic [CNT_W-1:0]  perf_issued_o,
   output logic [CNT_W-1:0]  perf_stall_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_MEM_WAIT, S_TRAP} state_t;

   localparam int            TW       = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [CW_W-1:0]   r_cw;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_cause;
   logic [TW-1:0]     r_tmo;
   logic              w_mem_op;
   logic              w_accept;
   logic              w_clr_tmo;
   logic              w_tmo_trap;

   assign w_mem_op = r_cw[MEM_OP_BIT];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_state <= S_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next  = r_state;
      instr_ready_o = 1'b0;
      cw_valid_o    = 1'b0;
      trap_o        = 1'b0;
      w_clr_tmo     = 1'b0;
      w_tmo_trap    = 1'b0;
      case (r_state)
         S_IDLE: begin
            instr_ready_o = !flush_i;
         end
         S_ISSUE: begin
            w_state_next = S_IDLE;
            if (!flush_i) begin
               cw_valid_o = 1'b1;
               // A memory word moves straight to the wait, so nothing new may be taken behind it.
               if (w_mem_op) begin
                  w_state_next = S_MEM_WAIT;
                  w_clr_tmo    = 1'b1;
               end else begin
                  instr_ready_o = 1'b1;
               end
            end
         end
         S_MEM_WAIT: begin
            cw_valid_o = 1'b1;
            if (mem_ack_i) begin
               w_state_next = S_IDLE;
            end else if (r_tmo == TMO_LAST) begin
               w_state_next = S_TRAP;
               w_tmo_trap   = 1'b1;
            end
         end
         default: begin
            trap_o = 1'b1;
            if (trap_ack_i) w_state_next = S_IDLE;
         end
      endcase
      w_accept = instr_valid_i && instr_ready_o;
      if (w_accept) w_state_next = invalid_instr_i ? S_TRAP : S_ISSUE;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_cw    <= '0;
         r_addr  <= '0;
         r_cause <= 2'b00;
         r_tmo   <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= cu_address_i;
            if (invalid_instr_i) r_cause <= 2'b01;
            else                 r_cw    <= cw_i;
         end
         if (w_tmo_trap) r_cause <= 2'b10;
         if (w_clr_tmo)
            r_tmo <= '0;
         else if (r_state == S_MEM_WAIT && !mem_ack_i && r_tmo != TMO_LAST)
            r_tmo <= r_tmo + 1'b1;
      end
   end

   assign control_word_o = cw_valid_o ? r_cw : '0;
   assign trap_cause_o   = trap_o ? r_cause : 2'b00;
   assign trap_addr_o    = trap_o ? r_addr : '0;

`ifdef BETA_USEQ_PERF_EN
   logic [CNT_W-1:0] r_perf_issued;
   logic [CNT_W-1:0] r_perf_stall;
   logic             w_issue_evt;
   logic             w_stall_evt;

   assign w_issue_evt = (r_state == S_ISSUE) && cw_valid_o;
   assign w_stall_evt = (r_state == S_MEM_WAIT) && !mem_ack_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_perf_issued <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (w_issue_evt) r_perf_issued <= r_perf_issued + 1'b1;
         if (w_stall_evt) r_perf_stall  <= r_perf_stall + 1'b1;
      end
   end

   assign perf_issued_o = r_perf_issued;
   assign perf_stall_o  = r_perf_stall;
`else
   assign perf_issued_o = '0;
   assign perf_stall_o  = '0;
`endif

endmodule
